// File: rtl/cond_logic.sv
// cond_logic: ARM-style conditional execution unit.
// Evaluates the instruction condition field against the registered NZCV
// status, qualifies the decoder's write requests with the result, updates
// the status register on committed flag-setting instructions, and keeps
// saturating counts of committed executed and skipped instructions.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic [3:0]       flags_q;
    logic [3:0]       flags_eff;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    cond_e            cond_code;
    logic             cond_ex;
    logic             commit;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    // Status view used for condition evaluation; reads as zero while reset is held
    // so the write qualifiers behave as if the status were already cleared.
    always_comb begin
        flags_eff = reset_n ? flags_q : '0;
        flag_n    = flags_eff[3];
        flag_z    = flags_eff[2];
        flag_c    = flags_eff[1];
        flag_v    = flags_eff[0];
        cond_code = cond_e'(Cond);
    end

    // Condition-code decode against the registered (pre-update) status.
    always_comb begin
        cond_ex = 1'b0;
        case (cond_code)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = !flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = !flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = !flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = !flag_v;
            COND_HI: cond_ex = flag_c && !flag_z;
            COND_LS: cond_ex = !flag_c || flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ex = flag_z || (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // Write qualification: nothing commits unless the pipeline advances and the condition passes.
    always_comb begin
        commit   = en && cond_ex;
        CondEx   = cond_ex;
        PCSrc    = PCS && commit;
        RegWrite = RegW && !NoWrite && commit;
        MemWrite = MemW && commit;
    end

    // Status register: N,Z and C,V groups load independently on a committed flag write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (en == 1'b1 && cond_ex == 1'b1) begin
            if (FlagW[1] == 1'b1) begin
                flags_q[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] == 1'b1) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Commit counters: exactly one moves per advancing instruction; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (clr_cnt) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (en == 1'b1) begin
            if (cond_ex == 1'b1) begin
                exec_q <= sat_inc(exec_q);
            end else begin
                skip_q <= sat_inc(skip_q);
            end
        end
    end

    // Registered state presented directly on the outputs.
    always_comb begin
        Flags     = flags_q;
        ExecCount = exec_q;
        SkipCount = skip_q;
    end

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed and randomized checks of cond_logic against a
// behavioural model of the condition rules, status register and counters.
module tb_cond_logic;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    Cond;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagW;
    logic          PCS;
    logic          RegW;
    logic          MemW;
    logic          NoWrite;
    logic          en;
    logic          clr_cnt;
    logic          PCSrc;
    logic          RegWrite;
    logic          MemWrite;
    logic          CondEx;
    logic [3:0]    Flags;
    logic [CW-1:0] ExecCount;
    logic [CW-1:0] SkipCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [3:0] m_flags = 4'b0000;
    int         m_exec  = 0;
    int         m_skip  = 0;

    cond_logic #(.CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .en       (en),
        .clr_cnt  (clr_cnt),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .ExecCount(ExecCount),
        .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs selected by Cond[3:1]; Cond[0]
    // inverts the sense, except that 1110 is always and 1111 is never.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic int sat(input int x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    // Drive one instruction (called just after a rising edge), check the
    // combinational outputs mid-cycle, clock it, update the model, check state.
    task automatic run(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw, input logic nowr,
                       input logic e, input logic clr, input logic rst_n);
        bit pass;
        logic [3:0] eff;
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw; MemW = memw;
        NoWrite = nowr; en = e; clr_cnt = clr; reset_n = rst_n;
        eff  = rst_n ? m_flags : 4'b0000;
        pass = cond_pass(c, eff);
        #3;
        check("condex",   CondEx,   pass);
        check("pcsrc",    PCSrc,    pcs && pass && e);
        check("regwrite", RegWrite, regw && pass && !nowr && e);
        check("memwrite", MemWrite, memw && pass && e);
        @(posedge clk);
        if (!rst_n) begin
            m_flags = 4'b0000;
            m_exec  = 0;
            m_skip  = 0;
        end else begin
            if (e && pass) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
            end
            if (clr) begin
                m_exec = 0;
                m_skip = 0;
            end else if (e) begin
                if (pass) m_exec = sat(m_exec);
                else      m_skip = sat(m_skip);
            end
        end
        #1;
        check("flags", Flags,     m_flags);
        check("exec",  ExecCount, m_exec);
        check("skip",  SkipCount, m_skip);
    endtask

    // Shorthand for a committed always-execute flag-setting instruction.
    task automatic set_flags(input logic [3:0] f);
        run(4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset: state clears, write qualifiers use zero status
        run(4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_flags", Flags, 0);
        check("reset_exec",  ExecCount, 0);

        // EQ fails on zero status and counts as skipped; SUBS sets Z; EQ then passes
        run(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("eq_skip", SkipCount, 1);
        set_flags(4'b0100);
        check("subs_flags", Flags, 4'b0100);
        run(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("eq_pass", CondEx, 1);

        // Named conditions on Z,C and N,V status
        set_flags(4'b0110);
        run(4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hi", CondEx, 0);
        run(4'b1001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ls", CondEx, 1);
        set_flags(4'b1001);
        run(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ge", CondEx, 1);
        run(4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("gt", CondEx, 1);
        run(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lt", CondEx, 0);

        // Full condition x status sweep, evaluated with the pipeline stalled
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                run(4'(c), 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        // Failing EQ with all writes requested: no side effects on writes or status
        set_flags(4'b0000);
        run(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("fail_flags", Flags, 4'b0000);
        // Passing CMP: register write suppressed, status updated
        run(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("cmp_flags", Flags, 4'b0110);

        // Stall with a pending flag write, then commit once
        for (int i = 0; i < 3; i++)
            run(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_flags", Flags, 4'b0110);
        set_flags(4'b1111);
        check("stall_commit", Flags, 4'b1111);

        // Never-execute: skipped, no status change
        run(4'b1111, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("nv_flags", Flags, 4'b1111);

        // Saturation and clear-over-increment
        run(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++)
            run(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("sat_exec", ExecCount, CNT_MAX);
        run(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_exec", ExecCount, 0);
        check("clr_skip", SkipCount, 0);

        // Reset on an edge carrying a committed flag write
        set_flags(4'b1010);
        run(4'b1110, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_flags", Flags, 4'b0000);
        check("rst_exec",  ExecCount, 0);
        // First edge out of reset is a normal edge
        set_flags(4'b0011);
        check("post_rst_flags", Flags, 4'b0011);
        check("post_rst_exec",  ExecCount, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            run(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                1'($urandom_range(24) == 0), 1'($urandom_range(49) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
